// File: rtl/self_trigger_ctrl.sv
// Board-level sequencer for the per-channel self_trigger blocks: arms the masked
// channels, merges their triggers into one req/ack transaction, then waits out a holdoff.
module self_trigger_ctrl #(
   parameter int NCHAN  = 5,
   parameter int HOLD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_enable,
   input  logic [NCHAN-1:0]  chan_mask,
   input  logic [HOLD_W-1:0] holdoff,
   input  logic [NCHAN-1:0]  ready_in,
   input  logic [NCHAN-1:0]  trig_in,
   input  logic              trig_ack,
   output logic [NCHAN-1:0]  chan_enable,
   output logic              trig_req,
   output logic [NCHAN-1:0]  trig_chan,
   output logic [31:0]       trig_count,
   output logic [15:0]       drop_count,
   output logic              armed
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_LISTEN  = 3'd2;
   localparam logic [2:0] ST_REQUEST = 3'd3;
   localparam logic [2:0] ST_HOLDOFF = 3'd4;

   logic [2:0]        state_reg, state_next;
   logic [NCHAN-1:0]  mask_reg, mask_next;
   logic [HOLD_W-1:0] hold_reg, hold_next;
   logic [HOLD_W-1:0] cnt_reg, cnt_next;
   logic [NCHAN-1:0]  trig_in_d_reg;
   logic [NCHAN-1:0]  chan_enable_reg;
   logic              trig_req_reg;
   logic [NCHAN-1:0]  trig_chan_reg, trig_chan_next;
   logic [31:0]       trig_count_reg, trig_count_next;
   logic [15:0]       drop_count_reg, drop_count_next;
   logic              armed_reg;

   logic [NCHAN-1:0]  edge_vec;
   logic [NCHAN-1:0]  not_ready;
   logic              any_edge;
   logic              any_not_ready;
   logic              drop_hit;

   // Per-channel rising-edge and readiness qualification against the latched mask
   genvar gi;
   generate
      for (gi = 0; gi < NCHAN; gi++) begin : g_chan
         assign edge_vec[gi]  = trig_in[gi] & ~trig_in_d_reg[gi] & mask_reg[gi];
         assign not_ready[gi] = mask_reg[gi] & ~ready_in[gi];
      end
   endgenerate

   assign any_edge      = |edge_vec;
   assign any_not_ready = |not_ready;

   always_comb begin
      state_next      = state_reg;
      mask_next       = mask_reg;
      hold_next       = hold_reg;
      cnt_next        = cnt_reg;
      trig_chan_next  = trig_chan_reg;
      trig_count_next = trig_count_reg;
      drop_count_next = drop_count_reg;
      drop_hit        = 1'b0;

      if (!run_enable) begin
         // Disable wins over everything; an edge in this cycle is neither accepted nor dropped
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               mask_next  = chan_mask;
               hold_next  = holdoff;
               state_next = ST_ARM;
            end
            ST_ARM: begin
               drop_hit = any_edge;
               if ((mask_reg != '0) && !any_not_ready) begin
                  state_next = ST_LISTEN;
               end
            end
            ST_LISTEN: begin
               if (any_edge) begin
                  trig_chan_next  = edge_vec;
                  trig_count_next = trig_count_reg + 32'd1;
                  state_next      = ST_REQUEST;
               end else if (any_not_ready) begin
                  state_next = ST_ARM;
               end
            end
            ST_REQUEST: begin
               drop_hit = any_edge;
               if (trig_ack) begin
                  if (hold_reg == '0) begin
                     state_next = ST_LISTEN;
                  end else begin
                     cnt_next   = hold_reg;
                     state_next = ST_HOLDOFF;
                  end
               end
            end
            ST_HOLDOFF: begin
               drop_hit = any_edge;
               cnt_next = cnt_reg - HOLD_W'(1);
               if (cnt_reg <= HOLD_W'(1)) begin
                  state_next = ST_LISTEN;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end

      if (drop_hit && (drop_count_reg != 16'hFFFF)) begin
         drop_count_next = drop_count_reg + 16'd1;
      end
   end

   // Outputs are derived from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         mask_reg        <= '0;
         hold_reg        <= '0;
         cnt_reg         <= '0;
         trig_in_d_reg   <= '0;
         chan_enable_reg <= '0;
         trig_req_reg    <= 1'b0;
         trig_chan_reg   <= '0;
         trig_count_reg  <= '0;
         drop_count_reg  <= '0;
         armed_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         mask_reg        <= mask_next;
         hold_reg        <= hold_next;
         cnt_reg         <= cnt_next;
         trig_in_d_reg   <= trig_in;
         chan_enable_reg <= (state_next != ST_IDLE) ? mask_next : '0;
         trig_req_reg    <= (state_next == ST_REQUEST);
         trig_chan_reg   <= trig_chan_next;
         trig_count_reg  <= trig_count_next;
         drop_count_reg  <= drop_count_next;
         armed_reg       <= (state_next == ST_LISTEN);
      end
   end

   assign chan_enable = chan_enable_reg;
   assign trig_req    = trig_req_reg;
   assign trig_chan   = trig_chan_reg;
   assign trig_count  = trig_count_reg;
   assign drop_count  = drop_count_reg;
   assign armed       = armed_reg;

endmodule

// File: tb/tb_self_trigger_ctrl.sv
// Scoreboard bench for self_trigger_ctrl: expected requests are queued as edges are
// driven and matched when trig_req rises; state/counter checks run inline.
module tb_self_trigger_ctrl;

   localparam int NCHAN  = 5;
   localparam int HOLD_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              run_enable;
   logic [NCHAN-1:0]  chan_mask;
   logic [HOLD_W-1:0] holdoff;
   logic [NCHAN-1:0]  ready_in;
   logic [NCHAN-1:0]  trig_in;
   logic              trig_ack;
   logic [NCHAN-1:0]  chan_enable;
   logic              trig_req;
   logic [NCHAN-1:0]  trig_chan;
   logic [31:0]       trig_count;
   logic [15:0]       drop_count;
   logic              armed;

   typedef struct packed {
      logic [NCHAN-1:0] chan;
      logic [31:0]      count;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_trig = 0;
   logic [15:0] exp_drop = 0;
   logic        req_prev = 1'b0;

   self_trigger_ctrl #(.NCHAN(NCHAN), .HOLD_W(HOLD_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_enable (run_enable),
      .chan_mask  (chan_mask),
      .holdoff    (holdoff),
      .ready_in   (ready_in),
      .trig_in    (trig_in),
      .trig_ack   (trig_ack),
      .chan_enable(chan_enable),
      .trig_req   (trig_req),
      .trig_chan  (trig_chan),
      .trig_count (trig_count),
      .drop_count (drop_count),
      .armed      (armed)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_trig(input logic [NCHAN-1:0] chan);
      exp_t e;
      exp_trig   = exp_trig + 32'd1;
      e.chan     = chan;
      e.count    = exp_trig;
      exp_q.push_back(e);
   endtask

   task automatic set_run(input logic [NCHAN-1:0] m, input logic [HOLD_W-1:0] h);
      chan_mask  = m;
      holdoff    = h;
      run_enable = 1'b1;
      tick();
      check_value("enable_latency", 32'(chan_enable), 32'(m));
   endtask

   task automatic restart(input logic [NCHAN-1:0] m, input logic [HOLD_W-1:0] h);
      run_enable = 1'b0;
      tick();
      check_value("idle_chan_enable", 32'(chan_enable), 32'd0);
      set_run(m, h);
   endtask

   // Scoreboard: each new request must match the oldest queued expectation
   always @(negedge clk) begin
      if (trig_req && !req_prev) begin
         check_value("req_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_value("req_trig_chan", 32'(trig_chan), 32'(e.chan));
            check_value("req_trig_count", trig_count, e.count);
            $display("TXN t=%0t trig_chan=%05b trig_count=%0h", $time, trig_chan, trig_count);
         end
      end
      req_prev = trig_req;
   end

   initial begin
      int n;
      rst_n      = 1'b0;
      run_enable = 1'b0;
      chan_mask  = '0;
      holdoff    = '0;
      ready_in   = '0;
      trig_in    = '0;
      trig_ack   = 1'b0;
      repeat (3) tick();
      check_value("rst_chan_enable", 32'(chan_enable), 32'd0);
      check_value("rst_trig_req", 32'(trig_req), 32'd0);
      check_value("rst_trig_chan", 32'(trig_chan), 32'd0);
      check_value("rst_trig_count", trig_count, 32'd0);
      check_value("rst_drop_count", 32'(drop_count), 32'd0);
      check_value("rst_armed", 32'(armed), 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic acceptance: mask 00101, H=4, ack two cycles after request
      ready_in = 5'b11111;
      set_run(5'b00101, 16'd4);
      tick();
      check_value("basic_armed", 32'(armed), 32'd1);
      trig_in = 5'b00100;
      push_trig(5'b00100);
      tick();
      check_value("basic_req", 32'(trig_req), 32'd1);
      check_value("basic_count", trig_count, exp_trig);
      trig_in = '0;
      tick();
      tick();
      trig_ack = 1'b1;
      tick();
      trig_ack = 1'b0;
      check_value("basic_req_drop", 32'(trig_req), 32'd0);
      check_value("basic_hold_armed", 32'(armed), 32'd0);
      for (int i = 5; i <= 8; i++) begin
         tick();
         check_value("basic_holdoff_armed", 32'(armed), 32'(i == 8));
      end

      // Simultaneous and unmasked edges; ack on the first request cycle, H=0
      restart(5'b00011, 16'd0);
      tick();
      trig_in = 5'b10011;
      push_trig(5'b00011);
      tick();
      check_value("simul_req", 32'(trig_req), 32'd1);
      trig_in  = '0;
      trig_ack = 1'b1;
      tick();
      trig_ack = 1'b0;
      check_value("simul_req_drop", 32'(trig_req), 32'd0);
      check_value("simul_armed", 32'(armed), 32'd1);
      check_value("simul_drop", 32'(drop_count), 32'(exp_drop));

      // Drops during REQUEST and HOLDOFF (H=6)
      restart(5'b00011, 16'd6);
      tick();
      trig_in = 5'b00010;
      push_trig(5'b00010);
      tick();
      trig_in = '0;
      tick();
      trig_in = 5'b00001;
      tick();
      trig_in  = '0;
      exp_drop = exp_drop + 16'd1;
      repeat (7) tick();
      check_value("drop_req_held", 32'(trig_req), 32'd1);
      trig_ack = 1'b1;
      tick();
      trig_ack = 1'b0;
      check_value("drop_req_drop", 32'(trig_req), 32'd0);
      trig_in = 5'b00001;
      tick();
      trig_in  = '0;
      exp_drop = exp_drop + 16'd1;
      check_value("drop_count", 32'(drop_count), 32'(exp_drop));
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (armed) begin
            n = i;
            break;
         end
      end
      check_value("drop_holdoff_len", 32'(n), 32'd5);
      check_value("drop_trig_count", trig_count, exp_trig);

      // Readiness gating and sustained input
      ready_in = 5'b10111;
      restart(5'b11111, 16'd0);
      tick();
      check_value("gate_armed_lo", 32'(armed), 32'd0);
      trig_in = 5'b00001;
      tick();
      exp_drop = exp_drop + 16'd1;
      tick();
      tick();
      check_value("gate_drop", 32'(drop_count), 32'(exp_drop));
      check_value("gate_still_arm", 32'(armed), 32'd0);
      ready_in = 5'b11111;
      tick();
      check_value("gate_armed_hi", 32'(armed), 32'd1);
      tick();
      tick();
      check_value("sustain_no_req", 32'(trig_req), 32'd0);
      trig_in = '0;
      tick();
      trig_in = 5'b00001;
      push_trig(5'b00001);
      tick();
      check_value("retrig_req", 32'(trig_req), 32'd1);
      trig_in  = '0;
      trig_ack = 1'b1;
      tick();
      trig_ack = 1'b0;
      check_value("retrig_armed", 32'(armed), 32'd1);
      ready_in = 5'b10111;
      tick();
      check_value("gate_back_arm", 32'(armed), 32'd0);
      ready_in = 5'b11111;

      // Run disable during a request, edge in the disable cycle, late ack
      tick();
      check_value("dis_armed", 32'(armed), 32'd1);
      trig_in = 5'b10000;
      push_trig(5'b10000);
      tick();
      check_value("dis_req", 32'(trig_req), 32'd1);
      run_enable = 1'b0;
      trig_in    = 5'b10010;
      tick();
      check_value("dis_req_drop", 32'(trig_req), 32'd0);
      check_value("dis_chan_enable", 32'(chan_enable), 32'd0);
      check_value("dis_armed_lo", 32'(armed), 32'd0);
      check_value("dis_trig_chan", 32'(trig_chan), 32'(5'b10000));
      trig_in  = '0;
      trig_ack = 1'b1;
      tick();
      trig_ack = 1'b0;
      check_value("dis_late_ack", 32'(trig_req), 32'd0);
      check_value("dis_drop", 32'(drop_count), 32'(exp_drop));
      check_value("dis_count", trig_count, exp_trig);
      set_run(5'b01000, 16'd0);
      tick();
      check_value("relatch_armed", 32'(armed), 32'd1);

      // Reset in the middle of HOLDOFF
      restart(5'b01000, 16'd10);
      tick();
      trig_in = 5'b01000;
      push_trig(5'b01000);
      tick();
      trig_in  = '0;
      trig_ack = 1'b1;
      tick();
      trig_ack = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check_value("mid_rst_chan_enable", 32'(chan_enable), 32'd0);
      check_value("mid_rst_trig_req", 32'(trig_req), 32'd0);
      check_value("mid_rst_trig_chan", 32'(trig_chan), 32'd0);
      check_value("mid_rst_trig_count", trig_count, 32'd0);
      check_value("mid_rst_drop_count", 32'(drop_count), 32'd0);
      check_value("mid_rst_armed", 32'(armed), 32'd0);
      exp_trig = 32'd0;
      exp_drop = 16'd0;

      // trig_count wrap from a preloaded 0xFFFFFFFF
      rst_n     = 1'b1;
      ready_in  = '0;
      chan_mask = 5'b00001;
      holdoff   = '0;
      tick();
      check_value("post_rst_enable", 32'(chan_enable), 32'd1);
      force dut.trig_count_reg = 32'hFFFF_FFFF;
      tick();
      release dut.trig_count_reg;
      exp_trig = 32'hFFFF_FFFF;
      check_value("preload_count", trig_count, exp_trig);
      ready_in = 5'b11111;
      tick();
      trig_in = 5'b00001;
      push_trig(5'b00001);
      tick();
      check_value("wrap_count", trig_count, 32'd0);
      trig_in  = '0;
      trig_ack = 1'b1;
      tick();
      trig_ack = 1'b0;

      // drop_count saturation: alternate ch0/ch1 rising every cycle while stuck in ARM
      ready_in = '0;
      restart(5'b00011, 16'd0);
      for (int i = 0; i < 65600; i++) begin
         trig_in = (i % 2 == 0) ? 5'b00001 : 5'b00010;
         tick();
         if (i == 99) check_value("drop_ramp", 32'(drop_count), 32'd100);
      end
      check_value("drop_saturate", 32'(drop_count), 32'h0000_FFFF);
      trig_in = '0;
      tick();

      check_value("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
